// File: rtl/mem_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_pkg
// Description : State encoding, pattern generator and compare-mask helper
//               shared by the memory test traffic generator and its checker.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_test_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_write   = 3'd1;
    localparam state_t c_st_wait_wr = 3'd2;
    localparam state_t c_st_read    = 3'd3;
    localparam state_t c_st_wait_rd = 3'd4;
    localparam state_t c_st_done    = 3'd5;

    // Widest data path the mask helper can describe.
    localparam int c_max_data_w = 1024;

    function automatic logic [31:0] pat32(input logic [31:0] seed, input logic [15:0] idx);
        return seed ^ {idx, ~idx};
    endfunction

    function automatic logic [c_max_data_w-1:0] xfer_mask(input int bytes);
        logic [c_max_data_w-1:0] m;
        m = '0;
        for (int b = 0; b < c_max_data_w; b++) begin
            m[b] = (b < bytes * 8);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_test_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_checker
// Description : Masked read-data compare, notification address check,
//               spurious-event detection and saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_test_checker
    import mem_test_pkg::*;
#(
    parameter int NOC_DATA_WIDTH = 512,
    parameter int MSG_ADDR_WIDTH = 64,
    parameter int XFER_BYTES     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      active,
    input  logic                      in_wait_wr,
    input  logic                      in_wait_rd,
    input  logic                      notif_val,
    input  logic [MSG_ADDR_WIDTH-1:0] notif_addr,
    input  logic [MSG_ADDR_WIDTH-1:0] exp_addr,
    input  logic                      resp_val,
    input  logic [NOC_DATA_WIDTH-1:0] resp_data,
    input  logic [31:0]               exp_pat,
    output logic [15:0]               err_count,
    output logic [15:0]               err_next
);

    localparam logic [c_max_data_w-1:0]   c_mask_all = xfer_mask(XFER_BYTES);
    localparam logic [NOC_DATA_WIDTH-1:0] c_mask     = c_mask_all[NOC_DATA_WIDTH-1:0];

    logic [NOC_DATA_WIDTH-1:0] w_exp_rep;
    logic                      w_addr_err;
    logic                      w_data_err;
    logic                      w_spur_notif;
    logic                      w_spur_resp;
    logic [1:0]                w_inc;
    logic [16:0]               w_sum;
    logic [15:0]               r_err_count;

    for (genvar k = 0; k < NOC_DATA_WIDTH / 32; k++) begin : g_exp_rep
        assign w_exp_rep[k*32 +: 32] = exp_pat;
    end

    assign w_addr_err   = in_wait_wr & notif_val & (notif_addr != exp_addr);
    assign w_data_err   = in_wait_rd & resp_val & ((resp_data & c_mask) != (w_exp_rep & c_mask));
    // Events seen while idle or finished are deliberately not counted.
    assign w_spur_notif = active & notif_val & ~in_wait_wr;
    assign w_spur_resp  = active & resp_val & ~in_wait_rd;

    assign w_inc    = {1'b0, w_addr_err | w_spur_notif} + {1'b0, w_data_err | w_spur_resp};
    assign w_sum    = {1'b0, r_err_count} + {15'd0, w_inc};
    assign err_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_err_count <= 16'd0;
        end else begin
            r_err_count <= err_next;
        end
    end

    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: rtl/mem_test_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_traffic_gen
// Description : Write / notify / read-back / compare sequencer for the memory
//               test tile, with run status and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_test_traffic_gen
    import mem_test_pkg::*;
#(
    parameter int                        MAC_INTERFACE_W     = 512,
    parameter int                        NOC_DATA_WIDTH      = 512,
    parameter int                        MSG_ADDR_WIDTH      = 64,
    parameter int                        MSG_DATA_SIZE_WIDTH = 16,
    parameter int                        NUM_XFERS           = 16,
    parameter logic [MSG_ADDR_WIDTH-1:0] BASE_ADDR           = 'h0,
    parameter logic [MSG_ADDR_WIDTH-1:0] ADDR_STRIDE         = 'h40,
    parameter int                        XFER_BYTES          = 32,
    parameter logic [31:0]               PAT_SEED            = 32'hC0DE_0000,
    parameter int                        TIMEOUT_CYC         = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           mac_val,
    output logic [MAC_INTERFACE_W-1:0]     mac_data,
    output logic [MSG_DATA_SIZE_WIDTH-1:0] mac_data_size,
    output logic [MSG_ADDR_WIDTH-1:0]      mac_data_addr,
    input  logic                           mac_rdy,
    input  logic                           write_complete_notif_val,
    input  logic [MSG_ADDR_WIDTH-1:0]      write_complete_notif_addr,
    output logic                           app_read_req_val,
    output logic [MSG_ADDR_WIDTH-1:0]      app_read_req_addr,
    output logic [MSG_DATA_SIZE_WIDTH-1:0] app_read_req_size,
    input  logic                           app_read_resp_val,
    input  logic [NOC_DATA_WIDTH-1:0]      app_read_resp_data,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [15:0]                    err_count,
    output logic [15:0]                    xfers_done
);

    localparam logic [15:0]                    c_last_idx     = 16'(NUM_XFERS - 1);
    localparam logic [31:0]                    c_timeout_last = 32'(TIMEOUT_CYC - 1);
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] c_size         = MSG_DATA_SIZE_WIDTH'(XFER_BYTES);

    state_t                        r_state;
    logic [15:0]                   r_idx;
    logic [MSG_ADDR_WIDTH-1:0]     r_addr;
    logic [31:0]                   r_cyc;
    logic                          r_mac_val;
    logic [MAC_INTERFACE_W-1:0]    r_mac_data;
    logic [MSG_DATA_SIZE_WIDTH-1:0] r_size;
    logic                          r_rd_val;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_pass;
    logic                          r_timeout;
    logic [15:0]                   r_xfers;

    logic                          w_active;
    logic                          w_timeout_hit;
    logic [15:0]                   w_next_idx;
    logic [31:0]                   w_next_pat;
    logic [MAC_INTERFACE_W-1:0]    w_mac_rep;
    logic [15:0]                   w_err_count;
    logic [15:0]                   w_err_next;

    assign w_active      = (r_state != c_st_idle) && (r_state != c_st_done);
    assign w_timeout_hit = (r_cyc == c_timeout_last);
    // Beat for the next WRITE entry: idx 0 from a start, idx+1 from WAIT_RD.
    assign w_next_idx    = (r_state == c_st_wait_rd) ? r_idx + 16'd1 : 16'd0;
    assign w_next_pat    = pat32(PAT_SEED, w_next_idx);

    for (genvar k = 0; k < MAC_INTERFACE_W / 32; k++) begin : g_mac_rep
        assign w_mac_rep[k*32 +: 32] = w_next_pat;
    end

    mem_test_checker #(
        .NOC_DATA_WIDTH (NOC_DATA_WIDTH),
        .MSG_ADDR_WIDTH (MSG_ADDR_WIDTH),
        .XFER_BYTES     (XFER_BYTES)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .clr        (start && !w_active),
        .active     (w_active),
        .in_wait_wr (r_state == c_st_wait_wr),
        .in_wait_rd (r_state == c_st_wait_rd),
        .notif_val  (write_complete_notif_val),
        .notif_addr (write_complete_notif_addr),
        .exp_addr   (r_addr),
        .resp_val   (app_read_resp_val),
        .resp_data  (app_read_resp_data),
        .exp_pat    (pat32(PAT_SEED, r_idx)),
        .err_count  (w_err_count),
        .err_next   (w_err_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_idx      <= 16'd0;
            r_addr     <= '0;
            r_cyc      <= 32'd0;
            r_mac_val  <= 1'b0;
            r_mac_data <= '0;
            r_size     <= '0;
            r_rd_val   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_xfers    <= 16'd0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state    <= c_st_write;
                        r_idx      <= 16'd0;
                        r_addr     <= BASE_ADDR;
                        r_cyc      <= 32'd0;
                        r_mac_val  <= 1'b1;
                        r_mac_data <= w_mac_rep;
                        r_size     <= c_size;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_xfers    <= 16'd0;
                    end
                end
                c_st_write: begin
                    if (mac_rdy) begin
                        r_mac_val <= 1'b0;
                        r_state   <= c_st_wait_wr;
                        r_cyc     <= 32'd0;
                    end
                end
                c_st_wait_wr: begin
                    if (write_complete_notif_val) begin
                        r_state  <= c_st_read;
                        r_rd_val <= 1'b1;
                        r_cyc    <= 32'd0;
                    end else if (w_timeout_hit) begin
                        r_state   <= c_st_done;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_cyc     <= 32'd0;
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                end
                c_st_read: begin
                    r_rd_val <= 1'b0;
                    r_state  <= c_st_wait_rd;
                    r_cyc    <= 32'd0;
                end
                c_st_wait_rd: begin
                    if (app_read_resp_val) begin
                        r_xfers <= r_xfers + 16'd1;
                        r_cyc   <= 32'd0;
                        if (r_idx == c_last_idx) begin
                            r_state <= c_st_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            // Include any error landing on this very cycle.
                            r_pass  <= (w_err_next == 16'd0);
                        end else begin
                            r_idx      <= w_next_idx;
                            r_addr     <= r_addr + ADDR_STRIDE;
                            r_state    <= c_st_write;
                            r_mac_val  <= 1'b1;
                            r_mac_data <= w_mac_rep;
                        end
                    end else if (w_timeout_hit) begin
                        r_state   <= c_st_done;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_cyc     <= 32'd0;
                    end else begin
                        r_cyc <= r_cyc + 32'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign mac_val           = r_mac_val;
    assign mac_data          = r_mac_data;
    assign mac_data_size     = r_size;
    assign mac_data_addr     = r_addr;
    assign app_read_req_val  = r_rd_val;
    assign app_read_req_addr = r_addr;
    assign app_read_req_size = r_size;
    assign busy              = r_busy;
    assign done              = r_done;
    assign pass              = r_pass;
    assign timeout           = r_timeout;
    assign err_count         = w_err_count;
    assign xfers_done        = r_xfers;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_test_traffic_gen
// Description : Self-checking bench with a behavioural memory-tile responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_test_traffic_gen;

    localparam int          MAC_W  = 256;
    localparam int          NOC_W  = 512;
    localparam int          AW     = 32;
    localparam int          SW     = 16;
    localparam int          NX     = 4;
    localparam logic [31:0] BASE   = 32'hFFFF_FF80;
    localparam logic [31:0] STRIDE = 32'h40;
    localparam int          XB     = 16;
    localparam logic [31:0] SEED   = 32'hC0DE_0000;
    localparam int          TO     = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mac_val;
    logic [MAC_W-1:0] mac_data;
    logic [SW-1:0]    mac_data_size;
    logic [AW-1:0]    mac_data_addr;
    logic             mac_rdy = 1'b1;
    logic             notif_val = 1'b0;
    logic [AW-1:0]    notif_addr = '0;
    logic             rd_val;
    logic [AW-1:0]    rd_addr;
    logic [SW-1:0]    rd_size;
    logic             resp_val = 1'b0;
    logic [NOC_W-1:0] resp_data = '0;
    logic             busy, done, pass, timeout;
    logic [15:0]      err_count, xfers_done;

    int n_cmp = 0;
    int n_fail = 0;

    // Responder configuration and observations.
    int               stall_en = 0, no_notif = 0, flip_idx = -1, inj_resp = 0;
    int               notif_cnt = 0, resp_cnt = 0, rd_count = 0;
    int               stall_viol = 0, rd_pulse_viol = 0, stall_cycles = 0;
    logic             prev_stall = 1'b0, prev_rd = 1'b0;
    logic [MAC_W-1:0] prev_data;
    logic [AW-1:0]    prev_addr, pend_notif_addr;
    logic [NOC_W-1:0] pend_resp;
    logic [XB*8-1:0]  mem [logic [31:0]];
    logic [AW-1:0]    wr_addr_q[$];
    logic [MAC_W-1:0] wr_data_q[$];
    logic [AW-1:0]    rd_addr_q[$];

    mem_test_traffic_gen #(
        .MAC_INTERFACE_W(MAC_W), .NOC_DATA_WIDTH(NOC_W), .MSG_ADDR_WIDTH(AW),
        .MSG_DATA_SIZE_WIDTH(SW), .NUM_XFERS(NX), .BASE_ADDR(BASE),
        .ADDR_STRIDE(STRIDE), .XFER_BYTES(XB), .PAT_SEED(SEED), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mac_val(mac_val), .mac_data(mac_data), .mac_data_size(mac_data_size),
        .mac_data_addr(mac_data_addr), .mac_rdy(mac_rdy),
        .write_complete_notif_val(notif_val), .write_complete_notif_addr(notif_addr),
        .app_read_req_val(rd_val), .app_read_req_addr(rd_addr), .app_read_req_size(rd_size),
        .app_read_resp_val(resp_val), .app_read_resp_data(resp_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .xfers_done(xfers_done)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] exp_addr(input int i);
        return BASE + 32'(i) * STRIDE;
    endfunction

    function automatic logic [MAC_W-1:0] exp_beat(input int i);
        logic [MAC_W-1:0] r;
        logic [15:0]      ii;
        ii = 16'(i);
        for (int k = 0; k < MAC_W / 32; k++) r[k*32 +: 32] = SEED ^ {ii, ~ii};
        return r;
    endfunction

    function automatic logic [NOC_W-1:0] rand_wide();
        logic [NOC_W-1:0] r;
        for (int k = 0; k < NOC_W / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // Memory tile model: notif 3 cycles after accept, resp 5 cycles after request.
    always @(negedge clk) begin
        if (rst) begin
            notif_cnt = 0; resp_cnt = 0; notif_val = 1'b0; resp_val = 1'b0;
            mac_rdy = 1'b1; prev_stall = 1'b0; prev_rd = 1'b0;
        end else begin
            notif_val = 1'b0;
            resp_val  = 1'b0;
            if (notif_cnt > 0) begin
                notif_cnt--;
                if (notif_cnt == 0) begin notif_val = 1'b1; notif_addr = pend_notif_addr; end
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin resp_val = 1'b1; resp_data = pend_resp; end
            end
            if (prev_stall && (mac_val !== 1'b1 || mac_data !== prev_data || mac_data_addr !== prev_addr))
                stall_viol++;
            mac_rdy    = (stall_en != 0) ? ($urandom_range(0, 99) >= 30) : 1'b1;
            prev_stall = mac_val && !mac_rdy;
            if (prev_stall) stall_cycles++;
            prev_data  = mac_data;
            prev_addr  = mac_data_addr;
            if (mac_val && mac_rdy) begin
                wr_addr_q.push_back(mac_data_addr);
                wr_data_q.push_back(mac_data);
                mem[mac_data_addr] = mac_data[XB*8-1:0];
                if (no_notif == 0) begin notif_cnt = 3; pend_notif_addr = mac_data_addr; end
            end
            if (rd_val) begin
                if (prev_rd) rd_pulse_viol++;
                rd_addr_q.push_back(rd_addr);
                pend_resp = rand_wide();
                if (mem.exists(rd_addr)) pend_resp[XB*8-1:0] = mem[rd_addr];
                if (rd_count == flip_idx) pend_resp[0] = ~pend_resp[0];
                rd_count++;
                resp_cnt = 5;
            end
            prev_rd = rd_val;
            if (inj_resp != 0 && mac_val && !resp_val) begin
                resp_val = 1'b1; resp_data = rand_wide(); inj_resp = 0;
            end
        end
    end

    task automatic clear_model();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); mem.delete();
        rd_count = 0; stall_viol = 0; rd_pulse_viol = 0; stall_cycles = 0;
    endtask

    task automatic pulse_start();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (!done && cycles < 2000) begin @(negedge clk); cycles++; end
        n_cmp++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done_wait: done=%b after %0d cycles, want 1", name, done, cycles); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({mac_val, rd_val, busy, done, pass, timeout} !== 6'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000", {mac_val, rd_val, busy, done, pass, timeout}); end
        n_cmp++; if (err_count !== 16'd0 || xfers_done !== 16'd0) begin n_fail++; $display("FAIL reset_counts: err=%0d xfers=%0d want 0/0", err_count, xfers_done); end
        n_cmp++; if (mac_data !== '0 || mac_data_addr !== '0 || rd_addr !== '0) begin n_fail++; $display("FAIL reset_data: data=%h addr=%h want 0", mac_data, mac_data_addr); end
        n_cmp++; if (mac_data_size !== '0 || rd_size !== '0) begin n_fail++; $display("FAIL reset_size: %0d/%0d want 0", mac_data_size, rd_size); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ideal();
        int cyc;
        clear_model(); stall_en = 0;
        pulse_start();
        wait_done("ideal", cyc);
        n_cmp++; if (pass !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ideal_status: pass=%b timeout=%b busy=%b want 1/0/0", pass, timeout, busy); end
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL ideal_err: got %0d want 0", err_count); end
        n_cmp++; if (xfers_done !== 16'(NX)) begin n_fail++; $display("FAIL ideal_xfers: got %0d want %0d", xfers_done, NX); end
        n_cmp++; if (mac_data_size !== 16'(XB) || rd_size !== 16'(XB)) begin n_fail++; $display("FAIL ideal_size: %0d/%0d want %0d", mac_data_size, rd_size, XB); end
        n_cmp++; if (wr_addr_q.size() != NX || rd_addr_q.size() != NX || rd_pulse_viol != 0) begin n_fail++; $display("FAIL ideal_counts: wr=%0d rd=%0d pulse_viol=%0d want %0d/%0d/0", wr_addr_q.size(), rd_addr_q.size(), rd_pulse_viol, NX, NX); end
        for (int i = 0; i < NX && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
            n_cmp++; if (wr_addr_q[i] !== exp_addr(i) || rd_addr_q[i] !== exp_addr(i)) begin n_fail++; $display("FAIL ideal_addr%0d: wr=%h rd=%h want %h", i, wr_addr_q[i], rd_addr_q[i], exp_addr(i)); end
            n_cmp++; if (wr_data_q[i] !== exp_beat(i)) begin n_fail++; $display("FAIL ideal_data%0d: got %h want %h", i, wr_data_q[i], exp_beat(i)); end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || pass !== 1'b1) begin n_fail++; $display("FAIL ideal_hold: done=%b pass=%b want 1/1", done, pass); end
    endtask

    task automatic test_stalls();
        int cyc, total_stalls;
        total_stalls = 0;
        stall_en = 1;
        for (int r = 0; r < 4; r++) begin
            clear_model();
            pulse_start();
            wait_done("stall", cyc);
            total_stalls += stall_cycles;
            n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stable: %0d unstable stall cycles, want 0", stall_viol); end
            n_cmp++; if (pass !== 1'b1 || err_count !== 16'd0 || xfers_done !== 16'(NX)) begin n_fail++; $display("FAIL stall_run: pass=%b err=%0d xfers=%0d want 1/0/%0d", pass, err_count, xfers_done, NX); end
        end
        n_cmp++; if (total_stalls == 0) begin n_fail++; $display("FAIL stall_seen: got 0 stall cycles, want >0"); end
        stall_en = 0;
    endtask

    task automatic test_bad_resp(input int fi);
        int cyc;
        clear_model(); flip_idx = fi;
        pulse_start();
        wait_done("bad_resp", cyc);
        n_cmp++; if (err_count !== 16'd1 || pass !== 1'b0 || xfers_done !== 16'(NX)) begin n_fail++; $display("FAIL bad_resp_idx%0d: err=%0d pass=%b xfers=%0d want 1/0/%0d", fi, err_count, pass, xfers_done, NX); end
        flip_idx = -1;
    endtask

    task automatic test_timeout();
        int cyc;
        clear_model(); no_notif = 1;
        pulse_start();
        wait_done("timeout", cyc);
        n_cmp++; if (timeout !== 1'b1 || pass !== 1'b0 || xfers_done !== 16'd0) begin n_fail++; $display("FAIL timeout_status: timeout=%b pass=%b xfers=%0d want 1/0/0", timeout, pass, xfers_done); end
        n_cmp++; if (cyc != TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, TO + 1); end
        n_cmp++; if (wr_addr_q.size() != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_writes: wr=%0d busy=%b want 1/0", wr_addr_q.size(), busy); end
        no_notif = 0;
    endtask

    task automatic test_spurious();
        int cyc;
        clear_model(); inj_resp = 1;
        pulse_start();
        wait_done("spurious", cyc);
        n_cmp++; if (err_count !== 16'd1 || pass !== 1'b0 || xfers_done !== 16'(NX) || timeout !== 1'b0) begin n_fail++; $display("FAIL spurious_run: err=%0d pass=%b xfers=%0d timeout=%b want 1/0/%0d/0", err_count, pass, xfers_done, timeout, NX); end
        inj_resp = 0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        clear_model();
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done("b2b", cyc);
        n_cmp++; if (pass !== 1'b1 || xfers_done !== 16'(NX) || wr_addr_q.size() != NX) begin n_fail++; $display("FAIL b2b_run: pass=%b xfers=%0d writes=%0d want 1/%0d/%0d", pass, xfers_done, wr_addr_q.size(), NX, NX); end
    endtask

    task automatic test_reset_mid();
        int cyc, seen;
        clear_model();
        pulse_start();
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 500) begin
            if (rd_val) seen++;
            if (seen < 2) begin @(negedge clk); cyc++; end
        end
        n_cmp++; if (seen != 2) begin n_fail++; $display("FAIL midrst_reach: read reqs=%0d want 2", seen); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mac_val, rd_val, busy, done, pass, timeout} !== 6'd0 || err_count !== 16'd0 || xfers_done !== 16'd0) begin n_fail++; $display("FAIL midrst_outputs: flags=%b err=%0d xfers=%0d want 0", {mac_val, rd_val, busy, done, pass, timeout}, err_count, xfers_done); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: done=%b busy=%b want 0/0", done, busy); end
        clear_model();
        pulse_start();
        wait_done("midrst", cyc);
        n_cmp++; if (pass !== 1'b1 || xfers_done !== 16'(NX) || wr_addr_q.size() == 0 || wr_addr_q[0] !== exp_addr(0)) begin n_fail++; $display("FAIL midrst_rerun: pass=%b xfers=%0d first_addr=%h want 1/%0d/%h", pass, xfers_done, (wr_addr_q.size() > 0) ? wr_addr_q[0] : '0, NX, exp_addr(0)); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal();
        test_stalls();
        test_bad_resp(2);
        test_bad_resp(NX - 1);
        test_timeout();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
